// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style character LCD driver: FSM states,
// o_io_lcd bit positions, power-up command table and long-command detection.
package lcd_pkg;

    typedef enum logic [2:0] {
        S_PWRUP = 3'd0,
        S_SETUP = 3'd1,
        S_EN_HI = 3'd2,
        S_HOLD  = 3'd3,
        S_WAIT  = 3'd4,
        S_IDLE  = 3'd5
    } lcd_state_t;

    localparam int LCD_ON = 31;
    localparam int LCD_EN = 10;
    localparam int LCD_RS = 9;
    localparam int LCD_RW = 8;

    localparam logic [1:0] INIT_LAST = 2'd3;

    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [7:0] CMD_HOME_ALT = 8'h03;

    // 8-bit bus / 2 lines, display on, clear, entry mode increment
    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = 8'h38;
            2'd1:    b = 8'h0C;
            2'd2:    b = 8'h01;
            2'd3:    b = 8'h06;
            default: b = 8'h38;
        endcase
        return b;
    endfunction

    // Clear and return-home commands need the long execution wait
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return (rs == 1'b0) &&
               ((data == CMD_CLEAR) || (data == CMD_HOME) || (data == CMD_HOME_ALT));
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter shared by every LCD FSM state. A load of N makes
// o_zero assert on the N-th cycle after the load; a load of 0 behaves as 1.
module lcd_timer #(
    parameter int W       = 8,
    parameter int RST_VAL = 1
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_zero
);

    localparam logic [W-1:0] RST_CNT = (RST_VAL > 1) ? W'(RST_VAL - 1) : {W{1'b0}};

    logic [W-1:0] count_r;

    // Holds remaining cycles minus one; saturates at zero until reloaded
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count_r <= RST_CNT;
        end else if (i_load) begin
            count_r <= (i_val == {W{1'b0}}) ? {W{1'b0}} : (i_val - {{(W-1){1'b0}}, 1'b1});
        end else if (count_r != {W{1'b0}}) begin
            count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign o_zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 character LCD driver: runs the power-up init sequence, then sends
// accepted command/data bytes as timed RS/DATA/EN strobes on o_io_lcd.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int T_PWRUP_CYC = 750_000,
    parameter int T_SETUP_CYC = 2,
    parameter int T_EN_CYC    = 25,
    parameter int T_HOLD_CYC  = 2,
    parameter int T_EXEC_CYC  = 2_000,
    parameter int T_CLEAR_CYC = 82_000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_vld,
    output logic        o_req_rdy,
    input  logic        i_req_rs,
    input  logic [7:0]  i_req_data,
    output logic        o_init_done,
    output logic        o_busy,
    output logic [31:0] o_io_lcd
);

    localparam int T_MAX = max2(max2(max2(T_PWRUP_CYC, T_SETUP_CYC), max2(T_EN_CYC, T_HOLD_CYC)),
                                max2(T_EXEC_CYC, T_CLEAR_CYC));
    localparam int TW = $clog2(T_MAX) + 1;

    localparam logic [TW-1:0] SETUP_V = TW'(T_SETUP_CYC);
    localparam logic [TW-1:0] EN_V    = TW'(T_EN_CYC);
    localparam logic [TW-1:0] HOLD_V  = TW'(T_HOLD_CYC);
    localparam logic [TW-1:0] EXEC_V  = TW'(T_EXEC_CYC);
    localparam logic [TW-1:0] CLEAR_V = TW'(T_CLEAR_CYC);

    lcd_state_t    state_r, state_s;
    logic          rs_r, rs_s;
    logic [7:0]    data_r, data_s;
    logic [1:0]    idx_r, idx_s;
    logic          init_done_r, init_done_s;
    logic          en_r, on_r, req_rdy_r, busy_r;
    logic          tmr_load_s;
    logic [TW-1:0] tmr_val_s;
    logic          tmr_zero_s;
    logic          accept_s;
    logic [31:0]   io_lcd_s;

    lcd_timer #(
        .W       (TW),
        .RST_VAL (T_PWRUP_CYC)
    ) u_timer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (tmr_load_s),
        .i_val   (tmr_val_s),
        .o_zero  (tmr_zero_s)
    );

    assign accept_s = i_req_vld && req_rdy_r;

    // Next-state, byte selection and timer reload for each phase of a strobe
    always_comb begin
        state_s     = state_r;
        rs_s        = rs_r;
        data_s      = data_r;
        idx_s       = idx_r;
        init_done_s = init_done_r;
        tmr_load_s  = 1'b0;
        tmr_val_s   = {TW{1'b0}};
        case (state_r)
            S_PWRUP: begin
                if (tmr_zero_s) begin
                    state_s    = S_SETUP;
                    rs_s       = 1'b0;
                    idx_s      = 2'd0;
                    data_s     = init_byte(2'd0);
                    tmr_load_s = 1'b1;
                    tmr_val_s  = SETUP_V;
                end else begin
                    state_s = S_PWRUP;
                end
            end
            S_SETUP: begin
                if (tmr_zero_s) begin
                    state_s    = S_EN_HI;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = EN_V;
                end else begin
                    state_s = S_SETUP;
                end
            end
            S_EN_HI: begin
                if (tmr_zero_s) begin
                    state_s    = S_HOLD;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = HOLD_V;
                end else begin
                    state_s = S_EN_HI;
                end
            end
            S_HOLD: begin
                if (tmr_zero_s) begin
                    state_s    = S_WAIT;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = is_long_cmd(rs_r, data_r) ? CLEAR_V : EXEC_V;
                end else begin
                    state_s = S_HOLD;
                end
            end
            S_WAIT: begin
                // During init, chain straight into the next table entry
                if (tmr_zero_s && !init_done_r && (idx_r != INIT_LAST)) begin
                    state_s    = S_SETUP;
                    idx_s      = idx_r + 2'd1;
                    rs_s       = 1'b0;
                    data_s     = init_byte(idx_r + 2'd1);
                    tmr_load_s = 1'b1;
                    tmr_val_s  = SETUP_V;
                end else if (tmr_zero_s) begin
                    state_s     = S_IDLE;
                    init_done_s = 1'b1;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_IDLE: begin
                if (accept_s) begin
                    state_s    = S_SETUP;
                    rs_s       = i_req_rs;
                    data_s     = i_req_data;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = SETUP_V;
                end else begin
                    state_s = S_IDLE;
                end
            end
            default: begin
                state_s    = S_PWRUP;
                tmr_load_s = 1'b1;
                tmr_val_s  = TW'(T_PWRUP_CYC);
            end
        endcase
    end

    // State and outputs are registered from next-state so pins track the FSM with no lag
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r     <= S_PWRUP;
            rs_r        <= 1'b0;
            data_r      <= 8'h00;
            idx_r       <= 2'd0;
            init_done_r <= 1'b0;
            en_r        <= 1'b0;
            on_r        <= 1'b0;
            req_rdy_r   <= 1'b0;
            busy_r      <= 1'b1;
        end else begin
            state_r     <= state_s;
            rs_r        <= rs_s;
            data_r      <= data_s;
            idx_r       <= idx_s;
            init_done_r <= init_done_s;
            en_r        <= (state_s == S_EN_HI);
            on_r        <= 1'b1;
            req_rdy_r   <= (state_s == S_IDLE) && init_done_s;
            busy_r      <= (state_s != S_IDLE);
        end
    end

    // Pack the pin word; RW is tied low and unused bits stay zero
    always_comb begin
        io_lcd_s         = 32'h0000_0000;
        io_lcd_s[LCD_ON] = on_r;
        io_lcd_s[LCD_EN] = en_r;
        io_lcd_s[LCD_RS] = rs_r;
        io_lcd_s[LCD_RW] = 1'b0;
        io_lcd_s[7:0]    = data_r;
    end

    assign o_io_lcd    = io_lcd_s;
    assign o_req_rdy   = req_rdy_r;
    assign o_init_done = init_done_r;
    assign o_busy      = busy_r;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl with shortened timing; a scoreboard queue
// holds the expected {RS,DATA} of every EN strobe in issue order.
module tb_lcd_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_vld;
    logic        req_rdy;
    logic        req_rs;
    logic [7:0]  req_data;
    logic        init_done;
    logic        busy;
    logic [31:0] io;

    int          checks    = 0;
    int          failures  = 0;
    int          cyc       = 0;
    int          n_strobes = 0;
    int          rise_cyc  = 0;
    bit          skip_width = 1'b0;
    logic [8:0]  sb [$];

    always #5 clk = ~clk;

    lcd_ctrl #(
        .T_PWRUP_CYC (20),
        .T_SETUP_CYC (2),
        .T_EN_CYC    (4),
        .T_HOLD_CYC  (2),
        .T_EXEC_CYC  (10),
        .T_CLEAR_CYC (30)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_req_vld   (req_vld),
        .o_req_rdy   (req_rdy),
        .i_req_rs    (req_rs),
        .i_req_data  (req_data),
        .o_init_done (init_done),
        .o_busy      (busy),
        .o_io_lcd    (io)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input int limit, output int n);
        n = 0;
        while (!req_rdy && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic push_init();
        sb.push_back(9'h038);
        sb.push_back(9'h00C);
        sb.push_back(9'h001);
        sb.push_back(9'h006);
    endtask

    // Called in cycle 0 after reset; runs until o_init_done and checks its timing
    task automatic check_init(input string tag);
        int n;
        bit rdy_early;
        n = 0;
        rdy_early = 1'b0;
        while (!init_done && n < 300) begin
            if (req_rdy) rdy_early = 1'b1;
            tick();
            n++;
            if (n == 1) chk({tag, "_on_bit"}, {31'd0, io[31]}, 32'd1);
        end
        chk({tag, "_done_cycle"}, n, 112);
        chk({tag, "_rdy_early"}, {31'd0, rdy_early}, 32'd0);
        chk({tag, "_idle_flags"}, {30'd0, req_rdy, busy}, 32'h2);
    endtask

    task automatic send(input string tag, input logic rs, input logic [7:0] d, input int exp_lat);
        int n;
        int acc;
        wait_rdy(200, n);
        chk({tag, "_rdy_before"}, {31'd0, req_rdy}, 32'd1);
        req_vld  = 1'b1;
        req_rs   = rs;
        req_data = d;
        sb.push_back({rs, d});
        acc = cyc;
        tick();
        req_vld = 1'b0;
        chk({tag, "_rs_data"}, {23'd0, io[9], io[7:0]}, {23'd0, rs, d});
        chk({tag, "_busy_flags"}, {30'd0, req_rdy, busy}, 32'h1);
        wait_rdy(200, n);
        chk({tag, "_en_latency"}, rise_cyc - acc, 32'd3);
        chk({tag, "_rdy_latency"}, cyc - acc, exp_lat);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Strobe monitor: pops the scoreboard on every EN rise, checks width and stability
    initial begin
        logic       en_prev;
        int         en_cnt;
        logic [8:0] cap;
        logic [8:0] exp;
        en_prev = 1'b0;
        en_cnt  = 0;
        cap     = 9'h000;
        forever begin
            @(negedge clk);
            if (io[10] && !en_prev) begin
                n_strobes++;
                rise_cyc = cyc;
                en_cnt   = 1;
                cap      = {io[9], io[7:0]};
                chk("rsvd_bits", {11'd0, io[30:11], io[8]}, 32'd0);
                if (sb.size() == 0) begin
                    chk("strobe_unexpected", {23'd0, cap}, 32'h1FF);
                end else begin
                    exp = sb.pop_front();
                    chk("strobe_byte", {23'd0, cap}, {23'd0, exp});
                end
            end else if (io[10] && en_prev) begin
                en_cnt++;
                chk("en_data_stable", {23'd0, io[9], io[7:0]}, {23'd0, cap});
            end else if (!io[10] && en_prev && !skip_width) begin
                chk("en_width", en_cnt, 32'd4);
            end else begin
                en_cnt = en_cnt;
            end
            en_prev = io[10];
        end
    end

    initial begin
        int n;
        int acc;
        logic [8:0] b4 [3];
        b4 = '{9'h080, 9'h1AB, 9'h1CD};

        reset    = 1'b1;
        req_vld  = 1'b0;
        req_rs   = 1'b0;
        req_data = 8'h00;
        repeat (3) tick();
        push_init();
        reset = 1'b0;

        // Reset state, then power-up init
        chk("reset_io", io, 32'h0);
        chk("reset_flags", {29'd0, req_rdy, init_done, busy}, 32'h1);
        check_init("init1");
        chk("init1_sb_empty", sb.size(), 32'd0);
        chk("init1_strobes", n_strobes, 32'd4);

        // Ordinary data, long clear command, data byte that looks like clear
        send("data41", 1'b1, 8'h41, 19);
        send("clear", 1'b0, 8'h01, 39);
        send("data01", 1'b1, 8'h01, 19);

        // Valid held high across three back-to-back bytes
        wait_rdy(200, n);
        req_vld = 1'b1;
        {req_rs, req_data} = b4[0];
        sb.push_back(b4[0]);
        for (int k = 0; k < 3; k++) begin
            acc = cyc;
            tick();
            if (k < 2) begin
                {req_rs, req_data} = b4[k+1];
                sb.push_back(b4[k+1]);
            end else begin
                req_vld = 1'b0;
            end
            chk("b2b_accepted", {31'd0, req_rdy}, 32'd0);
            wait_rdy(200, n);
            chk("b2b_rdy_latency", cyc - acc, 32'd19);
        end
        chk("b2b_sb_empty", sb.size(), 32'd0);
        chk("b2b_strobes", n_strobes, 32'd10);

        // Reset while EN is high
        wait_rdy(200, n);
        req_vld  = 1'b1;
        req_rs   = 1'b1;
        req_data = 8'h77;
        sb.push_back(9'h177);
        tick();
        req_vld = 1'b0;
        n = 0;
        while (!io[10] && n < 20) begin
            tick();
            n++;
        end
        chk("mid_en_seen", {31'd0, io[10]}, 32'd1);
        tick();
        skip_width = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        push_init();
        chk("midrst_io", io, 32'h0);
        chk("midrst_flags", {29'd0, req_rdy, init_done, busy}, 32'h1);

        // Request pending before init completes is taken on the first idle cycle
        req_vld  = 1'b1;
        req_rs   = 1'b1;
        req_data = 8'h5A;
        sb.push_back(9'h15A);
        check_init("init2");
        skip_width = 1'b0;
        acc = cyc;
        tick();
        req_vld = 1'b0;
        chk("early_req_accepted", {31'd0, req_rdy}, 32'd0);
        chk("early_req_rs_data", {23'd0, io[9], io[7:0]}, 32'h15A);
        wait_rdy(200, n);
        chk("early_req_en_latency", rise_cyc - acc, 32'd3);
        chk("early_req_rdy_latency", cyc - acc, 32'd19);

        repeat (5) tick();
        chk("final_sb_empty", sb.size(), 32'd0);
        chk("final_strobes", n_strobes, 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
